frogger_game_fsm: RTL and testbench

//  Top-level game sequencer for Frogger: owns game state, lives, score and level.

---
 rtl/frogger_game_fsm.sv | 179 +++++++++++++++++
 tb/tb_frogger_game_fsm.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frogger_game_fsm.sv
// Frogger game sequencer: owns game state, lives, score and level, and paces
// the death/goal pauses on VGA frame ticks.
module frogger_game_fsm #(
    parameter int unsigned c_INIT_LIVES      = 3,
    parameter int unsigned c_DEATH_FRAMES    = 60,
    parameter int unsigned c_GOAL_FRAMES     = 30,
    parameter int unsigned c_GOALS_PER_LEVEL = 5,
    parameter int unsigned c_MAX_LEVEL       = 7,
    parameter int unsigned c_MAX_SCORE       = 99,
    parameter int unsigned c_FLASH_FRAMES    = 8
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Game_Start,
    input  logic       i_Frame_Tick,
    input  logic       i_Collided,
    input  logic       i_Goal_Reached,
    output logic       o_Game_Active,
    output logic       o_Frog_Reset,
    output logic [2:0] o_Lives,
    output logic [6:0] o_Score,
    output logic [2:0] o_Level,
    output logic       o_Flash,
    output logic [2:0] o_State
);

    // state | meaning
    // IDLE  | power-up, waiting for start, play gated off
    // PLAY  | frog under player control
    // DEATH | death pause, frog sprite flashes
    // GOAL  | goal pause before respawn
    // OVER  | no lives left, waiting for start
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PLAY  = 3'd1;
    localparam logic [2:0] ST_DEATH = 3'd2;
    localparam logic [2:0] ST_GOAL  = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    localparam logic [2:0] LIVES_INIT = 3'(c_INIT_LIVES);
    localparam logic [7:0] DEATH_TC   = 8'(c_DEATH_FRAMES);
    localparam logic [7:0] GOAL_TC    = 8'(c_GOAL_FRAMES);
    localparam logic [3:0] GOALS_TC   = 4'(c_GOALS_PER_LEVEL);
    localparam logic [2:0] LEVEL_MAX  = 3'(c_MAX_LEVEL);
    localparam logic [6:0] SCORE_MAX  = 7'(c_MAX_SCORE);
    localparam logic [7:0] FLASH_TC   = 8'(c_FLASH_FRAMES);

    logic [2:0] state;
    logic [2:0] lives;
    logic [6:0] score;
    logic [2:0] level;
    logic [3:0] goal_cnt;
    logic [7:0] frame_cnt;
    logic [7:0] flash_cnt;
    logic [7:0] frame_nxt;
    logic [7:0] flash_nxt;
    logic       start_q, start_prev;
    logic       collide_q, collide_prev;
    logic       goal_q, goal_prev;
    logic       start_evt, collide_evt, goal_evt;

    // Edge regs run in every state, so a level held through a pause never re-fires.
    assign start_evt   = start_q & ~start_prev;
    assign collide_evt = collide_q & ~collide_prev;
    assign goal_evt    = goal_q & ~goal_prev;
    assign frame_nxt   = frame_cnt + 8'd1;
    assign flash_nxt   = flash_cnt + 8'd1;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state        <= ST_IDLE;
            lives        <= LIVES_INIT;
            score        <= 7'd0;
            level        <= 3'd1;
            goal_cnt     <= 4'd0;
            frame_cnt    <= 8'd0;
            flash_cnt    <= 8'd0;
            o_Flash      <= 1'b0;
            o_Frog_Reset <= 1'b0;
            start_q      <= 1'b0;
            start_prev   <= 1'b0;
            collide_q    <= 1'b0;
            collide_prev <= 1'b0;
            goal_q       <= 1'b0;
            goal_prev    <= 1'b0;
        end else begin
            start_q      <= i_Game_Start;
            start_prev   <= start_q;
            collide_q    <= i_Collided;
            collide_prev <= collide_q;
            goal_q       <= i_Goal_Reached;
            goal_prev    <= goal_q;
            o_Frog_Reset <= 1'b0;
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (start_evt) begin
                        state        <= ST_PLAY;
                        lives        <= LIVES_INIT;
                        score        <= 7'd0;
                        level        <= 3'd1;
                        goal_cnt     <= 4'd0;
                        frame_cnt    <= 8'd0;
                        o_Frog_Reset <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (collide_evt) begin
                        state     <= ST_DEATH;
                        frame_cnt <= 8'd0;
                        flash_cnt <= 8'd0;
                        o_Flash   <= 1'b1;
                        if (lives != 3'd0) begin
                            lives <= lives - 3'd1;
                        end
                    end else if (goal_evt) begin
                        state     <= ST_GOAL;
                        frame_cnt <= 8'd0;
                        if (score < SCORE_MAX) begin
                            score <= score + 7'd1;
                        end
                        if (goal_cnt + 4'd1 >= GOALS_TC) begin
                            goal_cnt <= 4'd0;
                            if (level < LEVEL_MAX) begin
                                level <= level + 3'd1;
                            end
                        end else begin
                            goal_cnt <= goal_cnt + 4'd1;
                        end
                    end
                end
                ST_DEATH: begin
                    if (i_Frame_Tick) begin
                        if (frame_nxt == DEATH_TC) begin
                            frame_cnt <= 8'd0;
                            flash_cnt <= 8'd0;
                            o_Flash   <= 1'b0;
                            if (lives == 3'd0) begin
                                state <= ST_OVER;
                            end else begin
                                state        <= ST_PLAY;
                                o_Frog_Reset <= 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_nxt;
                            if (flash_nxt == FLASH_TC) begin
                                flash_cnt <= 8'd0;
                                o_Flash   <= ~o_Flash;
                            end else begin
                                flash_cnt <= flash_nxt;
                            end
                        end
                    end
                end
                ST_GOAL: begin
                    if (i_Frame_Tick) begin
                        if (frame_nxt == GOAL_TC) begin
                            frame_cnt    <= 8'd0;
                            state        <= ST_PLAY;
                            o_Frog_Reset <= 1'b1;
                        end else begin
                            frame_cnt <= frame_nxt;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    frame_cnt <= 8'd0;
                    o_Flash   <= 1'b0;
                end
            endcase
        end
    end

    assign o_Game_Active = (state == ST_PLAY);
    assign o_Lives       = lives;
    assign o_Score       = score;
    assign o_Level       = level;
    assign o_State       = state;

endmodule

// File: tb/tb_frogger_game_fsm.sv
// Self-checking bench for frogger_game_fsm: randomized frame pacing checked
// against a rule-level game model (state, lives, score, level, goals).
module tb_frogger_game_fsm;

    localparam int S_IDLE  = 0;
    localparam int S_PLAY  = 1;
    localparam int S_DEATH = 2;
    localparam int S_GOAL  = 3;
    localparam int S_OVER  = 4;

    logic i_Clk = 1'b0;
    logic i_Rst_L = 1'b0;
    logic i_Game_Start = 1'b0;
    logic i_Frame_Tick = 1'b0;
    logic i_Collided = 1'b0;
    logic i_Goal_Reached = 1'b0;
    logic       o_Game_Active, o_Frog_Reset, o_Flash;
    logic [2:0] o_Lives, o_Level, o_State;
    logic [6:0] o_Score;
    logic [16:0] dut_vec;

    int errors = 0;
    int checks = 0;
    int fr_cnt = 0;
    int cyc = 0;
    int m_state, m_lives, m_score, m_level, m_goals;

    frogger_game_fsm dut (
        .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Game_Start(i_Game_Start),
        .i_Frame_Tick(i_Frame_Tick), .i_Collided(i_Collided),
        .i_Goal_Reached(i_Goal_Reached), .o_Game_Active(o_Game_Active),
        .o_Frog_Reset(o_Frog_Reset), .o_Lives(o_Lives), .o_Score(o_Score),
        .o_Level(o_Level), .o_Flash(o_Flash), .o_State(o_State)
    );

    always #5 i_Clk = ~i_Clk;

    always @(posedge i_Clk) begin
        cyc++;
        #1;
        if (o_Frog_Reset === 1'b1) fr_cnt++;
    end

    assign dut_vec = {o_State, o_Lives, o_Score, o_Level, o_Game_Active};

    // ---------------- reference model ----------------
    function automatic logic [16:0] model_vec();
        return {3'(m_state), 3'(m_lives), 7'(m_score), 3'(m_level), 1'(m_state == S_PLAY)};
    endfunction

    task automatic m_reset();
        m_state = S_IDLE; m_lives = 3; m_score = 0; m_level = 1; m_goals = 0;
    endtask

    task automatic m_events(input bit c, input bit g, input bit s);
        if ((m_state == S_IDLE || m_state == S_OVER) && s) begin
            m_state = S_PLAY; m_lives = 3; m_score = 0; m_level = 1; m_goals = 0;
        end else if (m_state == S_PLAY && c) begin
            m_state = S_DEATH;
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        end else if (m_state == S_PLAY && g) begin
            m_state = S_GOAL;
            m_score = (m_score < 99) ? m_score + 1 : 99;
            m_goals++;
            if (m_goals == 5) begin
                m_goals = 0;
                m_level = (m_level < 7) ? m_level + 1 : 7;
            end
        end
    endtask

    task automatic m_pause_done();
        if (m_state == S_DEATH) m_state = (m_lives == 0) ? S_OVER : S_PLAY;
        else if (m_state == S_GOAL) m_state = S_PLAY;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive_edge(input bit c, input bit g, input bit s);
        i_Collided = c; i_Goal_Reached = g; i_Game_Start = s;
        repeat (2) @(negedge i_Clk);
        i_Collided = 1'b0; i_Goal_Reached = 1'b0; i_Game_Start = 1'b0;
        m_events(c, g, s);
    endtask

    task automatic run_pause(input int n, input bit is_death, input bit poke, input string tag);
        int fr0;
        bit exp_flash;
        fr0 = fr_cnt;
        for (int k = 1; k <= n; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge i_Clk);
            if (poke && k == 10) drive_edge(1'b1, 1'b1, 1'b1);
            i_Frame_Tick = 1'b1;
            @(negedge i_Clk);
            i_Frame_Tick = 1'b0;
            if (k < n && (k % 7 == 0 || k == n - 1)) begin
                exp_flash = is_death && ((k / 8) % 2 == 0);
                checks++;
                if (dut_vec !== model_vec() || o_Flash !== exp_flash) begin
                    errors++;
                    $display("FAIL %s_tick%0d: got vec=%h flash=%b, expected vec=%h flash=%b",
                             tag, k, dut_vec, o_Flash, model_vec(), exp_flash);
                end
            end
        end
        m_pause_done();
        checks++;
        if (dut_vec !== model_vec() || o_Flash !== 1'b0 ||
            (fr_cnt - fr0) != ((m_state == S_PLAY) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s_exit: got vec=%h flash=%b frog_resets=%0d, expected vec=%h flash=0 frog_resets=%0d",
                     tag, dut_vec, o_Flash, fr_cnt - fr0, model_vec(), (m_state == S_PLAY) ? 1 : 0);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        m_reset();
        repeat (3) @(negedge i_Clk);
        checks++;
        if (dut_vec !== model_vec() || o_Flash !== 1'b0 || o_Frog_Reset !== 1'b0) begin
            errors++;
            $display("FAIL reset: got vec=%h flash=%b frog=%b, expected vec=%h flash=0 frog=0",
                     dut_vec, o_Flash, o_Frog_Reset, model_vec());
        end
        i_Rst_L = 1'b1;
        @(negedge i_Clk);
        drive_edge(1'b1, 1'b1, 1'b0);
        @(negedge i_Clk);
        checks++;
        if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL idle_ignore: got vec=%h, expected vec=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_start();
        int fr0;
        fr0 = fr_cnt;
        i_Game_Start = 1'b1;
        @(negedge i_Clk);
        checks++;
        if (o_State !== 3'(S_IDLE)) begin
            errors++;
            $display("FAIL start_latency: got state=%0d after 1 clock, expected %0d", o_State, S_IDLE);
        end
        @(negedge i_Clk);
        m_events(1'b0, 1'b0, 1'b1);
        checks++;
        if (dut_vec !== model_vec() || o_Frog_Reset !== 1'b1) begin
            errors++;
            $display("FAIL start_play: got vec=%h frog=%b, expected vec=%h frog=1",
                     dut_vec, o_Frog_Reset, model_vec());
        end
        i_Game_Start = 1'b0;
        repeat (3) @(negedge i_Clk);
        checks++;
        if (fr_cnt - fr0 != 1) begin
            errors++;
            $display("FAIL start_pulse: got %0d frog resets, expected 1", fr_cnt - fr0);
        end
    endtask

    task automatic test_death();
        drive_edge(1'b1, 1'b0, 1'b0);
        checks++;
        if (dut_vec !== model_vec() || o_Flash !== 1'b1) begin
            errors++;
            $display("FAIL death_entry: got vec=%h flash=%b, expected vec=%h flash=1",
                     dut_vec, o_Flash, model_vec());
        end
        run_pause(60, 1'b1, 1'b0, "death");
    endtask

    task automatic test_goals();
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(1, 4)) @(negedge i_Clk);
            drive_edge(1'b0, 1'b1, 1'b0);
            checks++;
            if (dut_vec !== model_vec() || o_Flash !== 1'b0) begin
                errors++;
                $display("FAIL goal_entry%0d: got vec=%h flash=%b, expected vec=%h flash=0",
                         i, dut_vec, o_Flash, model_vec());
            end
            run_pause(30, 1'b0, 1'b0, "goal");
        end
        checks++;
        if (o_Score !== 7'(m_score) || o_Level !== 3'd2) begin
            errors++;
            $display("FAIL five_goals: got score=%0d level=%0d, expected score=%0d level=2",
                     o_Score, o_Level, m_score);
        end
    endtask

    task automatic test_collide_goal_same();
        drive_edge(1'b1, 1'b1, 1'b0);
        checks++;
        if (dut_vec !== model_vec() || o_State !== 3'(S_DEATH)) begin
            errors++;
            $display("FAIL collide_wins: got vec=%h, expected vec=%h", dut_vec, model_vec());
        end
        run_pause(60, 1'b1, 1'b0, "cg_death");
    endtask

    task automatic test_ignored();
        int fr0;
        fr0 = fr_cnt;
        drive_edge(1'b0, 1'b0, 1'b1);
        @(negedge i_Clk);
        checks++;
        if (dut_vec !== model_vec() || fr_cnt != fr0) begin
            errors++;
            $display("FAIL start_in_play: got vec=%h resets=%0d, expected vec=%h resets=0",
                     dut_vec, fr_cnt - fr0, model_vec());
        end
        drive_edge(1'b1, 1'b0, 1'b0);
        run_pause(60, 1'b1, 1'b1, "poked_death");
    endtask

    task automatic test_game_over();
        int guard;
        guard = 0;
        while (m_state != S_OVER && guard < 8) begin
            guard++;
            drive_edge(1'b1, 1'b0, 1'b0);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL over_death%0d: got vec=%h, expected vec=%h", guard, dut_vec, model_vec());
            end
            run_pause(60, 1'b1, 1'b0, "over_death");
        end
        drive_edge(1'b1, 1'b1, 1'b0);
        @(negedge i_Clk);
        checks++;
        if (dut_vec !== model_vec() || o_State !== 3'(S_OVER) || o_Lives !== 3'd0) begin
            errors++;
            $display("FAIL game_over: got vec=%h, expected vec=%h", dut_vec, model_vec());
        end
        drive_edge(1'b0, 1'b0, 1'b1);
        checks++;
        if (dut_vec !== model_vec() || o_Lives !== 3'd3) begin
            errors++;
            $display("FAIL restart: got vec=%h, expected vec=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_held_collide();
        int c0;
        c0 = cyc;
        i_Collided = 1'b1;
        repeat (2) @(negedge i_Clk);
        m_events(1'b1, 1'b0, 1'b0);
        run_pause(60, 1'b1, 1'b0, "held_death");
        while (cyc - c0 < 200) @(negedge i_Clk);
        checks++;
        if (dut_vec !== model_vec() || o_Lives !== 3'd2) begin
            errors++;
            $display("FAIL held_collide: got vec=%h, expected vec=%h", dut_vec, model_vec());
        end
        i_Collided = 1'b0;
        repeat (3) @(negedge i_Clk);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 100; i++) begin
            drive_edge(1'b0, 1'b1, 1'b0);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL sat_goal%0d: got vec=%h, expected vec=%h", i, dut_vec, model_vec());
            end
            run_pause(30, 1'b0, 1'b0, "sat_goal");
        end
        checks++;
        if (o_Score !== 7'd99 || o_Level !== 3'd7) begin
            errors++;
            $display("FAIL saturation: got score=%0d level=%0d, expected score=99 level=7", o_Score, o_Level);
        end
    endtask

    task automatic test_reset_in_death();
        drive_edge(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            i_Frame_Tick = 1'b1;
            @(negedge i_Clk);
            i_Frame_Tick = 1'b0;
            @(negedge i_Clk);
        end
        #2 i_Rst_L = 1'b0;
        #1;
        m_reset();
        checks++;
        if (dut_vec !== model_vec() || o_Flash !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_death: got vec=%h flash=%b, expected vec=%h flash=0",
                     dut_vec, o_Flash, model_vec());
        end
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        @(negedge i_Clk);
        drive_edge(1'b0, 1'b0, 1'b1);
        checks++;
        if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL start_after_reset: got vec=%h, expected vec=%h", dut_vec, model_vec());
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_death();
        test_goals();
        test_collide_goal_same();
        test_ignored();
        test_game_over();
        test_held_collide();
        test_saturation();
        test_reset_in_death();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
